// File: rtl/capsense_events.sv
// Capacitive button front end: per-button sample debouncing, a pending-event
// stage with lowest-index priority, and a ready/valid event FIFO.
module capsense_events #(
  parameter int N          = 4,
  parameter int DEB_CNT    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sample_valid_i,
  input  logic [N-1:0]         sample_i,
  output logic [N-1:0]         stable_o,
  output logic                 evt_valid_o,
  input  logic                 evt_ready_i,
  output logic [$clog2(N)-1:0] evt_btn_o,
  output logic                 evt_press_o,
  output logic                 overflow_o,
  input  logic                 clear_ovf_i
);

  localparam int BW  = $clog2(N);
  localparam int CW  = $clog2(DEB_CNT + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CTW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(DEB_CNT - 1);
  localparam logic [CTW-1:0] FULL_CNT  = CTW'(FIFO_DEPTH);

  logic [CW-1:0]  cnt_q [N];
  logic [CW-1:0]  cnt_d [N];
  logic [N-1:0]   stable_q, stable_d;
  logic [N-1:0]   accept;
  logic [N-1:0]   pend_q, pend_d;
  logic [N-1:0]   pend_dir_q, pend_dir_d;
  logic           ovf_q, ovf_d;
  logic           drop_any;
  logic           pend_any;
  logic [BW-1:0]  sel;

  logic [BW:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [CTW-1:0] count_q;
  logic           empty, full, push, pop;

  // A differing sample advances the counter; the DEB_CNT-th in a row flips
  // the stable state. Any agreeing sample restarts the count.
  always_comb begin
    stable_d = stable_q;
    accept   = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (sample_valid_i) begin
      for (int i = 0; i < N; i++) begin
        if (sample_i[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          cnt_d[i]    = '0;
          stable_d[i] = ~stable_q[i];
          accept[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    pend_any = |pend_q;
    sel      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel = BW'(i);
      end
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign pop   = ~empty & evt_ready_i;
  assign push  = pend_any & (~full | pop);

  // A pending slot already occupied means the new change has nowhere to go,
  // so it is dropped and flagged rather than overwriting the older event.
  always_comb begin
    pend_d     = pend_q;
    pend_dir_d = pend_dir_q;
    drop_any   = 1'b0;
    if (push) begin
      pend_d[sel] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (accept[i]) begin
        if (pend_q[i]) begin
          drop_any = 1'b1;
        end else begin
          pend_d[i]     = 1'b1;
          pend_dir_d[i] = stable_d[i];
        end
      end
    end
    ovf_d = drop_any | (ovf_q & ~clear_ovf_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
      stable_q   <= '0;
      pend_q     <= '0;
      pend_dir_q <= '0;
      ovf_q      <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stable_q   <= stable_d;
      pend_q     <= pend_d;
      pend_dir_q <= pend_dir_d;
      ovf_q      <= ovf_d;
      if (push) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
      count_q <= count_q + CTW'(push) - CTW'(pop);
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_q] <= {sel, pend_dir_q[sel]};
    end
  end

  assign stable_o                 = stable_q;
  assign overflow_o               = ovf_q;
  assign evt_valid_o              = ~empty;
  assign {evt_btn_o, evt_press_o} = mem_q[rd_q];

endmodule

// File: tb/tb_capsense_events.sv
// Directed bench for capsense_events at default parameters (N=4, DEB_CNT=3,
// FIFO_DEPTH=4); every expected value is hand-derived.
module tb_capsense_events;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       sample_valid_i;
  logic [3:0] sample_i;
  logic [3:0] stable_o;
  logic       evt_valid_o;
  logic       evt_ready_i;
  logic [1:0] evt_btn_o;
  logic       evt_press_o;
  logic       overflow_o;
  logic       clear_ovf_i;

  int nCompared   = 0;
  int nMismatched = 0;

  capsense_events #(.N(4), .DEB_CNT(3), .FIFO_DEPTH(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sample_valid_i (sample_valid_i),
    .sample_i       (sample_i),
    .stable_o       (stable_o),
    .evt_valid_o    (evt_valid_o),
    .evt_ready_i    (evt_ready_i),
    .evt_btn_o      (evt_btn_o),
    .evt_press_o    (evt_press_o),
    .overflow_o     (overflow_o),
    .clear_ovf_i    (clear_ovf_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One strobe cycle; returns 1 ns into the following cycle.
  task automatic strobe(input logic [3:0] v);
    sample_valid_i = 1'b1;
    sample_i       = v;
    tick();
    sample_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; sample_valid_i = 1'b0; sample_i = '0;
    evt_ready_i = 1'b0; clear_ovf_i = 1'b0;
    #2;
    nCompared++; if (stable_o !== 4'b0000) begin nMismatched++; $display("[TB] FAIL reset_stable: got %b want 0000", stable_o); end
    nCompared++; if (evt_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %b want 0", evt_valid_o); end
    nCompared++; if (overflow_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ovf: got %b want 0", overflow_o); end
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_single_press();
    do_reset();
    strobe(4'b0010);
    strobe(4'b0010);
    nCompared++; if (stable_o !== 4'b0000) begin nMismatched++; $display("[TB] FAIL press_early: got %b want 0000", stable_o); end
    strobe(4'b0010);
    nCompared++; if (stable_o !== 4'b0010) begin nMismatched++; $display("[TB] FAIL press_stable: got %b want 0010", stable_o); end
    nCompared++; if (evt_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL press_valid_t1: got %b want 0", evt_valid_o); end
    tick();
    nCompared++; if (evt_valid_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL press_valid_t2: got %b want 1", evt_valid_o); end
    nCompared++; if ({evt_btn_o, evt_press_o} !== 3'b011) begin nMismatched++; $display("[TB] FAIL press_event: got btn %0d press %b want btn 1 press 1", evt_btn_o, evt_press_o); end
    tick();
    nCompared++; if (evt_valid_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL press_hold: got %b want 1", evt_valid_o); end
    evt_ready_i = 1'b1;
    tick();
    evt_ready_i = 1'b0;
    nCompared++; if (evt_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL press_popped: got %b want 0", evt_valid_o); end
  endtask

  // The third sample agrees with the stable state and restarts the count,
  // so three fresh differing samples (4, 5, 6) are needed.
  task automatic test_counter_clear();
    do_reset();
    strobe(4'b0010);
    strobe(4'b0010);
    strobe(4'b0000);
    nCompared++; if (stable_o !== 4'b0000) begin nMismatched++; $display("[TB] FAIL clr_s3: got %b want 0000", stable_o); end
    strobe(4'b0010);
    nCompared++; if (stable_o !== 4'b0000) begin nMismatched++; $display("[TB] FAIL clr_s4: got %b want 0000", stable_o); end
    strobe(4'b0010);
    nCompared++; if (stable_o !== 4'b0000) begin nMismatched++; $display("[TB] FAIL clr_s5: got %b want 0000", stable_o); end
    strobe(4'b0010);
    nCompared++; if (stable_o !== 4'b0010) begin nMismatched++; $display("[TB] FAIL clr_s6: got %b want 0010", stable_o); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] expEvt [3];
    expEvt[0] = 3'b001; expEvt[1] = 3'b011; expEvt[2] = 3'b111;
    do_reset();
    evt_ready_i = 1'b1;
    strobe(4'b1011);
    strobe(4'b1011);
    strobe(4'b1011);
    nCompared++; if (stable_o !== 4'b1011) begin nMismatched++; $display("[TB] FAIL b2b_stable: got %b want 1011", stable_o); end
    tick();
    for (int k = 0; k < 3; k++) begin
      nCompared++; if (evt_valid_o !== 1'b1 || {evt_btn_o, evt_press_o} !== expEvt[k]) begin nMismatched++; $display("[TB] FAIL b2b_evt%0d: got v %b btn %0d press %b want btn %0d press 1", k, evt_valid_o, evt_btn_o, evt_press_o, expEvt[k][2:1]); end
      tick();
    end
    nCompared++; if (evt_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_empty: got %b want 0", evt_valid_o); end
    evt_ready_i = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [2:0] expEvt [4];
    expEvt[0] = 3'b011; expEvt[1] = 3'b101; expEvt[2] = 3'b111; expEvt[3] = 3'b000;
    do_reset();
    strobe(4'b1111);
    strobe(4'b1111);
    strobe(4'b1111);
    repeat (4) tick();
    strobe(4'b1110);
    strobe(4'b1110);
    strobe(4'b1110);
    tick();
    nCompared++; if (overflow_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL full_ovf: got %b want 0", overflow_o); end
    nCompared++; if (evt_valid_o !== 1'b1 || {evt_btn_o, evt_press_o} !== 3'b001) begin nMismatched++; $display("[TB] FAIL full_head: got v %b btn %0d press %b want btn 0 press 1", evt_valid_o, evt_btn_o, evt_press_o); end
    evt_ready_i = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      nCompared++; if (evt_valid_o !== 1'b1 || {evt_btn_o, evt_press_o} !== expEvt[k]) begin nMismatched++; $display("[TB] FAIL full_drain%0d: got v %b btn %0d press %b want btn %0d press %b", k, evt_valid_o, evt_btn_o, evt_press_o, expEvt[k][2:1], expEvt[k][0]); end
      tick();
    end
    nCompared++; if (evt_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL full_empty: got %b want 0", evt_valid_o); end
    evt_ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    logic [2:0] expEvt [5];
    expEvt[0] = 3'b001; expEvt[1] = 3'b011; expEvt[2] = 3'b111;
    expEvt[3] = 3'b000; expEvt[4] = 3'b101;
    do_reset();
    repeat (3) strobe(4'b1011);
    repeat (3) strobe(4'b1010);
    repeat (3) strobe(4'b1110);
    tick();
    nCompared++; if (overflow_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf_before: got %b want 0", overflow_o); end
    repeat (3) strobe(4'b1010);
    nCompared++; if (stable_o !== 4'b1010) begin nMismatched++; $display("[TB] FAIL ovf_stable: got %b want 1010", stable_o); end
    nCompared++; if (overflow_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_set: got %b want 1", overflow_o); end
    tick();
    nCompared++; if (overflow_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_sticky: got %b want 1", overflow_o); end
    clear_ovf_i = 1'b1;
    tick();
    clear_ovf_i = 1'b0;
    nCompared++; if (overflow_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf_clear: got %b want 0", overflow_o); end
    strobe(4'b1110);
    strobe(4'b1110);
    clear_ovf_i = 1'b1;
    strobe(4'b1110);
    clear_ovf_i = 1'b0;
    nCompared++; if (overflow_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_set_wins: got %b want 1", overflow_o); end
    evt_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      nCompared++; if (evt_valid_o !== 1'b1 || {evt_btn_o, evt_press_o} !== expEvt[k]) begin nMismatched++; $display("[TB] FAIL ovf_drain%0d: got v %b btn %0d press %b want btn %0d press %b", k, evt_valid_o, evt_btn_o, evt_press_o, expEvt[k][2:1], expEvt[k][0]); end
      tick();
    end
    nCompared++; if (evt_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf_empty: got %b want 0", evt_valid_o); end
    evt_ready_i = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) strobe(4'b1111);
    repeat (3) tick();
    nCompared++; if (evt_valid_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL arst_queued: got %b want 1", evt_valid_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    nCompared++; if (evt_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL arst_valid: got %b want 0", evt_valid_o); end
    nCompared++; if (stable_o !== 4'b0000) begin nMismatched++; $display("[TB] FAIL arst_stable: got %b want 0000", stable_o); end
    tick();
    rst_ni = 1'b1;
    repeat (3) tick();
    nCompared++; if (evt_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL arst_discard: got %b want 0", evt_valid_o); end
    repeat (3) strobe(4'b0100);
    tick();
    nCompared++; if (evt_valid_o !== 1'b1 || {evt_btn_o, evt_press_o} !== 3'b101) begin nMismatched++; $display("[TB] FAIL arst_after: got v %b btn %0d press %b want btn 2 press 1", evt_valid_o, evt_btn_o, evt_press_o); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_counter_clear();
    test_back_to_back();
    test_fifo_full();
    test_overflow();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
